// File: rtl/response_fault_injector.sv
// Fault-injection stage on the PSL response path: registers every response and,
// when armed over MMIO, replaces the code of selected valid responses.
package psl_resp_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [7:0]  response;
    logic [8:0]  credits;
    logic [1:0]  cache_state;
    logic [12:0] cache_pos;
  } ResponseInterface;

  localparam logic [7:0] RESP_DONE    = 8'h00;
  localparam logic [7:0] RESP_AERROR  = 8'h01;
  localparam logic [7:0] RESP_DERROR  = 8'h03;
  localparam logic [7:0] RESP_NLOCK   = 8'h04;
  localparam logic [7:0] RESP_NRES    = 8'h05;
  localparam logic [7:0] RESP_FLUSHED = 8'h06;
  localparam logic [7:0] RESP_FAULT   = 8'h07;
  localparam logic [7:0] RESP_FAILED  = 8'h08;
  localparam logic [7:0] RESP_PAGED   = 8'h0A;

  function automatic logic [7:0] fault_code(input logic [2:0] sel);
    logic [7:0] code;
    unique case (sel)
      3'd0:    code = RESP_AERROR;
      3'd1:    code = RESP_DERROR;
      3'd2:    code = RESP_FAULT;
      3'd3:    code = RESP_FLUSHED;
      3'd4:    code = RESP_FAILED;
      3'd5:    code = RESP_NRES;
      3'd6:    code = RESP_NLOCK;
      default: code = RESP_DONE;
    endcase
    return code;
  endfunction

endpackage

module response_fault_injector
  import psl_resp_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_in,
  input  logic             enabled_in,
  input  logic [63:0]      inject_config,
  input  ResponseInterface response_in,
  output ResponseInterface response_out,
  output logic [63:0]      inject_status
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BURST = 2'd2,
    ST_END   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]             fault_sel;
    logic [COUNT_WIDTH-1:0] trigger_index;
    logic [7:0]             burst_len;
    logic                   paged_first;
    logic                   repeat_en;
  } cfg_t;

  // MMIO numbering is bit 0 = MSB, so field bit k sits at vector bit 63-k.
  logic inject_enable;
  cfg_t cfg_in;
  logic unused_cfg;

  assign inject_enable         = inject_config[63];
  assign cfg_in.fault_sel      = inject_config[62:60];
  assign cfg_in.trigger_index  = COUNT_WIDTH'(inject_config[59:44]);
  assign cfg_in.burst_len      = inject_config[43:36];
  assign cfg_in.paged_first    = inject_config[35];
  assign cfg_in.repeat_en      = inject_config[34];
  assign unused_cfg            = ^inject_config[33:0];

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] resp_count_q, resp_count_d;
  logic [7:0]             burst_rem_q, burst_rem_d;
  cfg_t                   cfg_q, cfg_d;
  logic [31:0]            injected_q, injected_d;
  ResponseInterface       response_q, response_d;

  logic [7:0]             burst_eff;
  logic [COUNT_WIDTH-1:0] cnt_cur;
  logic                   arm_eval;
  logic                   subst;
  logic [7:0]             subst_code;

  assign burst_eff = (cfg_q.burst_len == 8'd0) ? 8'd1 : cfg_q.burst_len;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    resp_count_d = resp_count_q;
    burst_rem_d  = burst_rem_q;
    cfg_d        = cfg_q;
    injected_d   = injected_q;
    response_d   = response_in;
    cnt_cur      = resp_count_q;
    arm_eval     = 1'b0;
    subst        = 1'b0;
    subst_code   = fault_code(cfg_q.fault_sel);

    if (!(inject_enable && enabled_in)) begin
      state_d      = ST_IDLE;
      resp_count_d = '0;
      burst_rem_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          resp_count_d = '0;
          cfg_d        = cfg_in;
          state_d      = ST_ARMED;
        end
        ST_ARMED: arm_eval = 1'b1;
        ST_BURST: begin
          if (response_in.valid && response_in.response != RESP_PAGED) begin
            subst       = 1'b1;
            burst_rem_d = burst_rem_q - 8'd1;
            if (burst_rem_q == 8'd1) state_d = ST_END;
          end
        end
        ST_END: begin
          // A restart treats the response arriving now as index 0 of the new pass.
          if (cfg_q.repeat_en) begin
            cnt_cur      = '0;
            resp_count_d = '0;
            arm_eval     = 1'b1;
            state_d      = ST_ARMED;
          end
        end
      endcase
    end

    if (arm_eval && response_in.valid) begin
      resp_count_d = (cnt_cur == '1) ? cnt_cur : cnt_cur + 1'b1;
      if (cnt_cur == cfg_q.trigger_index) begin
        subst = 1'b1;
        if (cfg_q.paged_first) begin
          subst_code  = RESP_PAGED;
          burst_rem_d = burst_eff;
          state_d     = ST_BURST;
        end else begin
          burst_rem_d = burst_eff - 8'd1;
          state_d     = (burst_eff == 8'd1) ? ST_END : ST_BURST;
        end
      end
    end

    if (subst && cfg_q.fault_sel != 3'd7) begin
      response_d.response = subst_code;
      if (injected_q != '1) injected_d = injected_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking ones.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      resp_count_q <= '0;
      burst_rem_q  <= '0;
      cfg_q        <= '0;
      injected_q   <= '0;
      response_q   <= '0;
    end else begin
      state_q      <= state_d;
      resp_count_q <= resp_count_d;
      burst_rem_q  <= burst_rem_d;
      cfg_q        <= cfg_d;
      injected_q   <= injected_d;
      response_q   <= response_d;
    end
  end

  assign response_out  = response_q;
  assign inject_status = {injected_q, 16'(resp_count_q), 1'b0, state_q, 13'd0};

endmodule

// File: tb/tb_response_fault_injector.sv
// Bench for response_fault_injector: directed vector table, async-reset sequence,
// and randomized traffic compared against a behavioural model.
module tb_response_fault_injector;
  import psl_resp_pkg::*;

  logic             clock = 1'b0;
  logic             rst_in;
  logic             enabled_in;
  logic [63:0]      inject_config;
  ResponseInterface response_in;
  ResponseInterface response_out;
  logic [63:0]      inject_status;

  response_fault_injector #(.COUNT_WIDTH(16)) dut (
    .clock        (clock),
    .rst_in       (rst_in),
    .enabled_in   (enabled_in),
    .inject_config(inject_config),
    .response_in  (response_in),
    .response_out (response_out),
    .inject_status(inject_status)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] FCODE [8] = '{RESP_AERROR, RESP_DERROR, RESP_FAULT, RESP_FLUSHED,
                                       RESP_FAILED, RESP_NRES, RESP_NLOCK, RESP_DONE};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkcfg(input bit ie, input int sel, input int trig,
                                        input int burst, input bit pf, input bit rep);
    logic [63:0] c;
    c        = '0;
    c[63]    = ie;
    c[62:60] = 3'(sel);
    c[59:44] = 16'(trig);
    c[43:36] = 8'(burst);
    c[35]    = pf;
    c[34]    = rep;
    return c;
  endfunction

  // Behavioural model: phase uses the architectural state codes 0..3.
  int      m_phase, m_seen, m_left, m_trig, m_burst, m_sel;
  bit      m_pf, m_rep;
  longint  m_inj;

  task automatic model_reset();
    m_phase = 0; m_seen = 0; m_left = 0; m_trig = 0; m_burst = 0; m_sel = 0;
    m_pf = 0; m_rep = 0; m_inj = 0;
  endtask

  task automatic model_step(input logic [63:0] cfg, input bit en, input ResponseInterface r,
                            output ResponseInterface exp);
    bit         hit;
    logic [7:0] code;
    exp  = r;
    hit  = 0;
    code = 8'h00;
    if (!cfg[63] || !en) begin
      m_phase = 0;
      m_seen  = 0;
    end else if (m_phase == 0) begin
      m_sel   = int'(cfg[62:60]);
      m_trig  = int'(cfg[59:44]);
      m_burst = int'(cfg[43:36]);
      m_pf    = cfg[35];
      m_rep   = cfg[34];
      m_phase = 1;
      m_seen  = 0;
    end else begin
      if (m_phase == 3 && m_rep) begin
        m_phase = 1;
        m_seen  = 0;
      end
      if (r.valid && m_phase == 1) begin
        if (m_seen == m_trig) begin
          hit     = 1;
          code    = m_pf ? RESP_PAGED : FCODE[m_sel];
          m_left  = (m_burst == 0 ? 1 : m_burst) - (m_pf ? 0 : 1);
          m_phase = (m_left == 0) ? 3 : 2;
        end
        if (m_seen < 65535) m_seen++;
      end else if (r.valid && m_phase == 2 && r.response != RESP_PAGED) begin
        hit  = 1;
        code = FCODE[m_sel];
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end
    if (hit && m_sel != 7) begin
      exp.response = code;
      if (m_inj < 64'hFFFF_FFFF) m_inj++;
    end
  endtask

  task automatic apply(input logic [63:0] cfg, input bit en, input ResponseInterface r);
    inject_config = cfg;
    enabled_in    = en;
    response_in   = r;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          do_rst;
    logic [63:0] cfg;
    bit          en;
    bit          valid;
    logic [7:0]  code;
    logic [7:0]  exp_code;
    int          exp_st;
    int          exp_inj;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit rs, input logic [63:0] cfg, input bit en, input bit v,
                                  input logic [7:0] code, input logic [7:0] ec,
                                  input int st, input int inj, input int cnt);
    vec_t t;
    t.do_rst = rs; t.cfg = cfg; t.en = en; t.valid = v; t.code = code; t.exp_code = ec;
    t.exp_st = st; t.exp_inj = inj; t.exp_cnt = cnt;
    vecs.push_back(t);
  endfunction

  initial begin
    ResponseInterface r, e;
    logic [63:0]      c;
    bit               en;

    rst_in        = 1'b0;
    enabled_in    = 1'b0;
    inject_config = '0;
    response_in   = '0;
    #3;
    do_reset();
    check("reset response_out", {22'd0, response_out}, 64'd0);
    check("reset status", inject_status, 64'd0);

    // A: injection disabled, pure pass-through
    c = mkcfg(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) add_vec(k == 0, c, 1, 1, RESP_DONE, RESP_DONE, 0, 0, 0);
    // B: DERROR at #5..#7
    c = mkcfg(1, 1, 5, 3, 0, 0);
    add_vec(1, c, 1, 0, RESP_DONE, RESP_DONE, 1, 0, 0);
    for (int k = 0; k < 12; k++)
      add_vec(0, c, 1, 1, RESP_DONE, (k >= 5 && k <= 7) ? RESP_DERROR : RESP_DONE,
              k < 5 ? 1 : (k < 7 ? 2 : 3), k < 5 ? 0 : (k <= 7 ? k - 4 : 3), k < 5 ? k + 1 : -1);
    // C: paged_first with a PAGED exemption inside the burst
    c = mkcfg(1, 2, 0, 2, 1, 0);
    add_vec(1, c, 1, 0, RESP_DONE,  RESP_DONE,  1, 0, 0);
    add_vec(0, c, 1, 1, RESP_DONE,  RESP_PAGED, 2, 1, -1);
    add_vec(0, c, 1, 1, RESP_DONE,  RESP_FAULT, 2, 2, -1);
    add_vec(0, c, 1, 1, RESP_PAGED, RESP_PAGED, 2, 2, -1);
    add_vec(0, c, 1, 1, RESP_DONE,  RESP_FAULT, 3, 3, -1);
    // D: repeat mode, FLUSHED every third response
    c = mkcfg(1, 3, 2, 1, 0, 1);
    add_vec(1, c, 1, 0, RESP_DONE, RESP_DONE, 1, 0, 0);
    for (int k = 0; k < 9; k++)
      add_vec(0, c, 1, 1, RESP_DONE, (k % 3 == 2) ? RESP_FLUSHED : RESP_DONE,
              (k % 3 == 2) ? 3 : 1, (k + 1) / 3, (k % 3 == 2) ? -1 : (k % 3) + 1);
    // E: abort mid-burst, then re-arm with new config
    c = mkcfg(1, 0, 0, 8, 0, 0);
    add_vec(1, c, 1, 0, RESP_DONE, RESP_DONE,   1, 0, 0);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_AERROR, 2, 1, -1);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_AERROR, 2, 2, -1);
    add_vec(0, c, 0, 1, RESP_DONE, RESP_DONE,   0, 2, 0);
    c = mkcfg(1, 4, 1, 1, 0, 0);
    add_vec(0, c, 1, 0, RESP_DONE, RESP_DONE,   1, 2, 0);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_DONE,   1, 2, 1);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_FAILED, 3, 3, -1);
    // F: burst_len 0 acts as 1; config rewrites while armed are ignored; invalid not counted
    c = mkcfg(1, 6, 1, 0, 0, 0);
    add_vec(1, c, 1, 0, RESP_DONE, RESP_DONE, 1, 0, 0);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_DONE, 1, 0, 1);
    c = mkcfg(1, 2, 0, 5, 1, 0);
    add_vec(0, c, 1, 0, RESP_DONE, RESP_DONE,  1, 0, 1);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_NLOCK, 3, 1, -1);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_DONE,  3, 1, -1);
    // G: PAGED trigger with paged_first=0 is still replaced
    c = mkcfg(1, 5, 0, 2, 0, 0);
    add_vec(1, c, 1, 0, RESP_DONE,  RESP_DONE,  1, 0, 0);
    add_vec(0, c, 1, 1, RESP_PAGED, RESP_NRES,  2, 1, -1);
    add_vec(0, c, 1, 1, RESP_PAGED, RESP_PAGED, 2, 1, -1);
    add_vec(0, c, 1, 1, RESP_DONE,  RESP_NRES,  3, 2, -1);
    // H: fault_sel 7 advances without substituting; inject_enable low returns to IDLE
    c = mkcfg(1, 7, 0, 1, 0, 0);
    add_vec(1, c, 1, 0, RESP_DONE, RESP_DONE, 1, 0, 0);
    add_vec(0, c, 1, 1, RESP_DONE, RESP_DONE, 3, 0, -1);
    add_vec(0, mkcfg(0, 7, 0, 1, 0, 0), 1, 1, RESP_DONE, RESP_DONE, 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      r             = '0;
      r.valid       = vecs[i].valid;
      r.tag         = 8'(i);
      r.tag_parity  = ~^r.tag;
      r.response    = vecs[i].code;
      r.credits     = 9'(i * 3);
      r.cache_state = 2'(i);
      r.cache_pos   = 13'(i * 7);
      apply(vecs[i].cfg, vecs[i].en, r);
      e          = r;
      e.response = vecs[i].exp_code;
      check($sformatf("vec%0d response", i), {22'd0, response_out}, {22'd0, e});
      check($sformatf("vec%0d state", i), 64'(inject_status[15:13]), 64'(vecs[i].exp_st));
      check($sformatf("vec%0d injected", i), 64'(inject_status[63:32]), 64'(vecs[i].exp_inj));
      if (vecs[i].exp_cnt >= 0)
        check($sformatf("vec%0d resp_count", i), 64'(inject_status[31:16]), 64'(vecs[i].exp_cnt));
    end

    // Asynchronous reset in the middle of a burst
    do_reset();
    c = mkcfg(1, 0, 0, 8, 0, 0);
    r = '0;
    apply(c, 1, r);
    r.valid = 1'b1; r.response = RESP_DONE; r.tag = 8'h5A;
    apply(c, 1, r);
    apply(c, 1, r);
    check("mid-burst state", 64'(inject_status[15:13]), 64'd2);
    response_in = r;
    #2;
    rst_in = 1'b1;
    #1;
    check("async reset valid", 64'(response_out.valid), 64'd0);
    check("async reset status", inject_status, 64'd0);
    rst_in = 1'b0;
    apply(c, 1, r);
    check("post-reset passthrough", {22'd0, response_out}, {22'd0, r});
    check("post-reset state", 64'(inject_status[15:13]), 64'd1);

    // Randomized traffic against the model
    do_reset();
    c = mkcfg(1, 1, 2, 2, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        int sel;
        bit pf;
        sel = int'($urandom_range(0, 7));
        pf  = (sel != 7) && ($urandom_range(0, 1) == 1);
        c   = mkcfg($urandom_range(0, 9) != 0, sel, int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 4)), pf, $urandom_range(0, 1) == 1);
        c[33:0] = 34'({$urandom, $urandom});
      end
      en            = ($urandom_range(0, 99) >= 3);
      r.valid       = ($urandom_range(0, 99) < 70);
      r.tag         = 8'($urandom);
      r.tag_parity  = 1'($urandom);
      r.credits     = 9'($urandom);
      r.cache_state = 2'($urandom);
      r.cache_pos   = 13'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    r.response = RESP_PAGED;
        2, 3:    r.response = RESP_DONE;
        default: r.response = 8'($urandom);
      endcase
      model_step(c, en, r, e);
      apply(c, en, r);
      check($sformatf("rand%0d response", n), {22'd0, response_out}, {22'd0, e});
      check($sformatf("rand%0d state", n), 64'(inject_status[15:13]), 64'(m_phase));
      check($sformatf("rand%0d injected", n), 64'(inject_status[63:32]), 64'(m_inj));
      if (m_phase <= 1)
        check($sformatf("rand%0d resp_count", n), 64'(inject_status[31:16]), 64'(m_seen));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
